reservation_station: RTL



---
 rtl/reservation_station_pkg.sv | 26 ++
 rtl/reservation_station_rs_pick.sv | 23 ++
 rtl/reservation_station.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_pkg.sv
// Shared size and opcode definitions for the reservation station slice.
// Also provides the opcode-class helper used to screen dispatcher traffic.
package reservation_station_pkg;

  localparam int DATA_WID    = 32;
  localparam int ADDR_WID    = 32;
  localparam int OPCODE_WID  = 7;
  localparam int FUNCT3_WID  = 3;
  localparam int ROB_POS_WID = 4;
  localparam int RS_SIZE     = 16;
  localparam int RS_ID_WID   = 4;

  localparam logic [OPCODE_WID-1:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [OPCODE_WID-1:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_WID-1:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [OPCODE_WID-1:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [OPCODE_WID-1:0] OPCODE_ARITHI = 7'b0010011;
  localparam logic [OPCODE_WID-1:0] OPCODE_ARITH  = 7'b0110011;

  // True for the op classes this station executes on the ALU.
  function automatic logic is_rs_opcode(input logic [OPCODE_WID-1:0] op);
    return op inside {OPCODE_ARITH, OPCODE_ARITHI, OPCODE_BRANCH,
                      OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC};
  endfunction

endpackage

// File: rtl/reservation_station_rs_pick.sv
// Lowest-index priority encoder: reports whether any request bit is set and
// the index of the lowest set bit. Used for free-slot and ready-entry search.
module rs_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] i_req,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  // Scan from the top down so the lowest set bit wins the last assignment.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // an output unassigned in combinational logic infers a latch.
    o_found = |i_req;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer feeding the ALU. Accepts dispatched ops tagged
// with a ROB slot, snoops ALU/LSB result broadcasts to wake pending operands
// and sends the lowest-index ready entry to a registered ALU issue port.
// Optional build macro RS_BYPASS_EN: an incoming op whose operands are
// already available goes straight to the ALU port when nothing stored is
// ready, skipping allocation.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE   = reservation_station_pkg::RS_SIZE,
  parameter int RS_ID_W   = reservation_station_pkg::RS_ID_WID,
  parameter int ROB_POS_W = reservation_station_pkg::ROB_POS_WID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  // dispatcher interface
  input  logic                  issue_en,
  input  logic [OPCODE_WID-1:0] issue_opcode,
  input  logic [FUNCT3_WID-1:0] issue_funct3,
  input  logic                  issue_funct7,
  input  logic                  issue_rs1_rdy,
  input  logic [DATA_WID-1:0]   issue_rs1_val,
  input  logic [ROB_POS_W-1:0]  issue_rs1_tag,
  input  logic                  issue_rs2_rdy,
  input  logic [DATA_WID-1:0]   issue_rs2_val,
  input  logic [ROB_POS_W-1:0]  issue_rs2_tag,
  input  logic [DATA_WID-1:0]   issue_imm,
  input  logic [ADDR_WID-1:0]   issue_pc,
  input  logic [ROB_POS_W-1:0]  issue_rob_pos,
  output logic                  rs_full,
  // ALU issue port
  output logic                  alu_en,
  output logic [OPCODE_WID-1:0] alu_opcode,
  output logic [FUNCT3_WID-1:0] alu_funct3,
  output logic                  alu_funct7,
  output logic [DATA_WID-1:0]   alu_val1,
  output logic [DATA_WID-1:0]   alu_val2,
  output logic [DATA_WID-1:0]   alu_imm,
  output logic [ADDR_WID-1:0]   alu_pc,
  output logic [ROB_POS_W-1:0]  alu_rob_pos,
  // result broadcasts
  input  logic                  alu_result,
  input  logic [ROB_POS_W-1:0]  alu_result_rob_pos,
  input  logic [DATA_WID-1:0]   alu_result_val,
  input  logic                  lsb_result,
  input  logic [ROB_POS_W-1:0]  lsb_result_rob_pos,
  input  logic [DATA_WID-1:0]   lsb_result_val
);

  // Entry storage
  logic [RS_SIZE-1:0]    r_busy;
  logic [RS_SIZE-1:0]    r_rs1_rdy;
  logic [RS_SIZE-1:0]    r_rs2_rdy;
  logic [RS_SIZE-1:0]    r_funct7;
  logic [OPCODE_WID-1:0] r_opcode  [RS_SIZE];
  logic [FUNCT3_WID-1:0] r_funct3  [RS_SIZE];
  logic [DATA_WID-1:0]   r_rs1_val [RS_SIZE];
  logic [DATA_WID-1:0]   r_rs2_val [RS_SIZE];
  logic [ROB_POS_W-1:0]  r_rs1_tag [RS_SIZE];
  logic [ROB_POS_W-1:0]  r_rs2_tag [RS_SIZE];
  logic [DATA_WID-1:0]   r_imm     [RS_SIZE];
  logic [ADDR_WID-1:0]   r_pc      [RS_SIZE];
  logic [ROB_POS_W-1:0]  r_rob_pos [RS_SIZE];

  logic [RS_SIZE-1:0]  w_free_req;
  logic [RS_SIZE-1:0]  w_ready_req;
  logic                w_free_found;
  logic [RS_ID_W-1:0]  w_free_idx;
  logic                w_sel_found;
  logic [RS_ID_W-1:0]  w_sel_idx;
  logic                w_in_rs1_rdy;
  logic [DATA_WID-1:0] w_in_rs1_val;
  logic                w_in_rs2_rdy;
  logic [DATA_WID-1:0] w_in_rs2_val;
  logic                w_bypass;
  logic                w_alloc;

  // Resolve one operand against this cycle's broadcasts; ALU wins over LSB.
  function automatic logic [DATA_WID:0] snoop(
    input logic                 op_rdy,
    input logic [DATA_WID-1:0]  op_val,
    input logic [ROB_POS_W-1:0] op_tag
  );
    snoop = {op_rdy, op_val};
    if (!op_rdy) begin
      if (alu_result && op_tag == alu_result_rob_pos)
        snoop = {1'b1, alu_result_val};
      else if (lsb_result && op_tag == lsb_result_rob_pos)
        snoop = {1'b1, lsb_result_val};
    end
  endfunction

  assign w_free_req  = ~r_busy;
  assign w_ready_req = r_busy & r_rs1_rdy & r_rs2_rdy;

  rs_pick #(.N(RS_SIZE), .W(RS_ID_W)) u_free_pick (
    .i_req   (w_free_req),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_pick #(.N(RS_SIZE), .W(RS_ID_W)) u_ready_pick (
    .i_req   (w_ready_req),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  assign rs_full = ~w_free_found;

  // Same-cycle forwarding of the incoming op's operands from the broadcasts.
  always_comb begin
    {w_in_rs1_rdy, w_in_rs1_val} = snoop(issue_rs1_rdy, issue_rs1_val, issue_rs1_tag);
    {w_in_rs2_rdy, w_in_rs2_val} = snoop(issue_rs2_rdy, issue_rs2_val, issue_rs2_tag);
  end

`ifdef RS_BYPASS_EN
  assign w_bypass = issue_en && w_in_rs1_rdy && w_in_rs2_rdy && !w_sel_found;
`else
  assign w_bypass = 1'b0;
`endif

  // A slot freed by this cycle's dispatch is not visible to the free search.
  assign w_alloc = issue_en && !w_bypass && w_free_found;

  // Control state and ALU issue port: flush, select/dispatch, allocate.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || rollback) begin
      r_busy      <= '0;
      alu_en      <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
    end else if (rdy) begin
      if (w_sel_found) begin
        r_busy[w_sel_idx] <= 1'b0;
        alu_en      <= 1'b1;
        alu_opcode  <= r_opcode[w_sel_idx];
        alu_funct3  <= r_funct3[w_sel_idx];
        alu_funct7  <= r_funct7[w_sel_idx];
        alu_val1    <= r_rs1_val[w_sel_idx];
        alu_val2    <= r_rs2_val[w_sel_idx];
        alu_imm     <= r_imm[w_sel_idx];
        alu_pc      <= r_pc[w_sel_idx];
        alu_rob_pos <= r_rob_pos[w_sel_idx];
      end else if (w_bypass) begin
        alu_en      <= 1'b1;
        alu_opcode  <= issue_opcode;
        alu_funct3  <= issue_funct3;
        alu_funct7  <= issue_funct7;
        alu_val1    <= w_in_rs1_val;
        alu_val2    <= w_in_rs2_val;
        alu_imm     <= issue_imm;
        alu_pc      <= issue_pc;
        alu_rob_pos <= issue_rob_pos;
      end else begin
        alu_en <= 1'b0;
      end
      if (w_alloc) r_busy[w_free_idx] <= 1'b1;
    end
  end

  // Entry payload: operand wakeup for busy entries, fill on allocation.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is deliberately not reset; every field is
    // qualified by r_busy, which is reset, so stale contents are never used.
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          {r_rs1_rdy[i], r_rs1_val[i]} <= snoop(r_rs1_rdy[i], r_rs1_val[i], r_rs1_tag[i]);
          {r_rs2_rdy[i], r_rs2_val[i]} <= snoop(r_rs2_rdy[i], r_rs2_val[i], r_rs2_tag[i]);
        end
      end
      if (w_alloc) begin
        r_opcode[w_free_idx]  <= issue_opcode;
        r_funct3[w_free_idx]  <= issue_funct3;
        r_funct7[w_free_idx]  <= issue_funct7;
        r_rs1_rdy[w_free_idx] <= w_in_rs1_rdy;
        r_rs1_val[w_free_idx] <= w_in_rs1_val;
        r_rs1_tag[w_free_idx] <= issue_rs1_tag;
        r_rs2_rdy[w_free_idx] <= w_in_rs2_rdy;
        r_rs2_val[w_free_idx] <= w_in_rs2_val;
        r_rs2_tag[w_free_idx] <= issue_rs2_tag;
        r_imm[w_free_idx]     <= issue_imm;
        r_pc[w_free_idx]      <= issue_pc;
        r_rob_pos[w_free_idx] <= issue_rob_pos;
      end
    end
  end

  // The dispatcher must not issue into a full station (unless bypassed).
  a_no_issue_when_full : assert property (
    @(posedge clk) disable iff (rst || rollback)
    (rdy && issue_en) |-> (!rs_full || w_bypass));

  // Only ALU-class ops belong in this station.
  a_rs_opcode : assert property (
    @(posedge clk) disable iff (rst || rollback)
    (rdy && issue_en) |-> is_rs_opcode(issue_opcode));

endmodule
